// File: rtl/seg7_pkg.sv
// seg7_pkg: segment code table shared by the 7-segment encoder and the
// scan decoder, so both sides agree on exactly one set of glyphs.
//   Segment order: bit6=g ... bit0=a, active-high.
//   SEG7_CODE_0..F : glyphs for hex digits 0-F
//   SEG7_BLANK     : all segments off
//   seg7_encode()  : nibble -> segment pattern
package seg7_pkg;

    localparam logic [6:0] SEG7_CODE_0 = 7'h3F;
    localparam logic [6:0] SEG7_CODE_1 = 7'h06;
    localparam logic [6:0] SEG7_CODE_2 = 7'h5B;
    localparam logic [6:0] SEG7_CODE_3 = 7'h4F;
    localparam logic [6:0] SEG7_CODE_4 = 7'h66;
    localparam logic [6:0] SEG7_CODE_5 = 7'h6D;
    localparam logic [6:0] SEG7_CODE_6 = 7'h7D;
    localparam logic [6:0] SEG7_CODE_7 = 7'h07;
    localparam logic [6:0] SEG7_CODE_8 = 7'h7F;
    localparam logic [6:0] SEG7_CODE_9 = 7'h6F;
    localparam logic [6:0] SEG7_CODE_A = 7'h77;
    localparam logic [6:0] SEG7_CODE_B = 7'h7C;
    localparam logic [6:0] SEG7_CODE_C = 7'h39;
    localparam logic [6:0] SEG7_CODE_D = 7'h5E;
    localparam logic [6:0] SEG7_CODE_E = 7'h79;
    localparam logic [6:0] SEG7_CODE_F = 7'h71;
    localparam logic [6:0] SEG7_BLANK  = 7'h00;

    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG7_CODE_0;
            4'h1:    seg = SEG7_CODE_1;
            4'h2:    seg = SEG7_CODE_2;
            4'h3:    seg = SEG7_CODE_3;
            4'h4:    seg = SEG7_CODE_4;
            4'h5:    seg = SEG7_CODE_5;
            4'h6:    seg = SEG7_CODE_6;
            4'h7:    seg = SEG7_CODE_7;
            4'h8:    seg = SEG7_CODE_8;
            4'h9:    seg = SEG7_CODE_9;
            4'hA:    seg = SEG7_CODE_A;
            4'hB:    seg = SEG7_CODE_B;
            4'hC:    seg = SEG7_CODE_C;
            4'hD:    seg = SEG7_CODE_D;
            4'hE:    seg = SEG7_CODE_E;
            default: seg = SEG7_CODE_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed 7-segment display bus.
//   seg_in  [6:0]        : segment lines, bit6=g ... bit0=a, active-high
//   dig_sel [DIGITS-1:0] : digit strobes, one-hot while a digit is lit
//   master : the scanner driving the display
//   slave  : an observer of the bus (the scan decoder)
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]        seg_in;
    logic [DIGITS-1:0] dig_sel;

    modport master (output seg_in, output dig_sel);
    modport slave  (input  seg_in, input  dig_sel);
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment pattern to hex nibble.
//   seg    in  7 : segment pattern, bit6=g ... bit0=a
//   hit    out 1 : pattern is one of the 16 glyphs 0-F
//   nibble out 4 : decoded value, 0 when hit is low
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG7_CODE_0: nibble = 4'h0;
            SEG7_CODE_1: nibble = 4'h1;
            SEG7_CODE_2: nibble = 4'h2;
            SEG7_CODE_3: nibble = 4'h3;
            SEG7_CODE_4: nibble = 4'h4;
            SEG7_CODE_5: nibble = 4'h5;
            SEG7_CODE_6: nibble = 4'h6;
            SEG7_CODE_7: nibble = 4'h7;
            SEG7_CODE_8: nibble = 4'h8;
            SEG7_CODE_9: nibble = 4'h9;
            SEG7_CODE_A: nibble = 4'hA;
            SEG7_CODE_B: nibble = 4'hB;
            SEG7_CODE_C: nibble = 4'hC;
            SEG7_CODE_D: nibble = 4'hD;
            SEG7_CODE_E: nibble = 4'hE;
            SEG7_CODE_F: nibble = 4'hF;
            default:     hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the hex value shown on each digit of a
// multiplexed 7-segment display bus (readback / self-test path).
//   clk         in  1          : clock, rising edge
//   rst         in  1          : synchronous active-high reset
//   bus         slave modport  : seg_in[6:0], dig_sel[DIGITS-1:0]
//   value_out   out 4*DIGITS   : nibble i = last decoded value of digit i
//   digit_valid out DIGITS     : digit i holds a legal decoded value
//   digit_err   out DIGITS     : last commit on digit i was illegal
//   update      out 1          : one-cycle pulse on every commit
// Optional feature: define SEG7_DEC_TIMEOUT_EN to add a per-digit refresh
// timeout that drops valid/err for a digit not re-committed within
// TIMEOUT_CYCLES cycles.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7_scan_decoder_if.slave      bus,
    output logic [4*DIGITS-1:0]     value_out,
    output logic [DIGITS-1:0]       digit_valid,
    output logic [DIGITS-1:0]       digit_err,
    output logic                    update
);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_decoder: DIGITS must be 1..8");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("seg7_scan_decoder: STABLE_CYCLES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("seg7_scan_decoder: TIMEOUT_CYCLES must be >= 1");
    end

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [SW-1:0]     s1, s2, s3;
    logic [CW-1:0]     cnt;
    logic [DIGITS-1:0] s2_dig;
    logic [6:0]        s2_seg;
    logic              sel_onehot;
    logic              same;
    logic              commit;
    logic [DIGITS-1:0] commit_vec;
    logic              dec_hit;
    logic [3:0]        dec_nib;

    assign s2_dig     = s2[SW-1:7];
    assign s2_seg     = s2[6:0];
    assign sel_onehot = $onehot(s2_dig);
    assign same       = (s2 == s3);
    // Fires only on the step into saturation, so a held sample commits once.
    assign commit     = sel_onehot && same && (cnt == CW'(STABLE_CYCLES - 1));
    assign commit_vec = commit ? s2_dig : '0;

    seg7_pattern_decode u_pattern_decode (
        .seg    (s2_seg),
        .hit    (dec_hit),
        .nibble (dec_nib)
    );

`ifdef SEG7_DEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]     tcnt [DIGITS];
    logic [DIGITS-1:0] expire;

    always_comb begin
        expire = '0;
        for (int i = 0; i < DIGITS; i++) begin
            expire[i] = !commit_vec[i] && (tcnt[i] == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (rst || commit_vec[i]) begin
                tcnt[i] <= '0;
            end else if (tcnt[i] != TW'(TIMEOUT_CYCLES)) begin
                tcnt[i] <= tcnt[i] + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            cnt         <= '0;
            value_out   <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            update      <= 1'b0;
        end else begin
            s1     <= {bus.dig_sel, bus.seg_in};
            s2     <= s1;
            s3     <= s2;
            update <= commit;

            if (!sel_onehot) begin
                cnt <= '0;
            end else if (!same) begin
                cnt <= CW'(1);
            end else if (cnt != CW'(STABLE_CYCLES)) begin
                cnt <= cnt + 1'b1;
            end

`ifdef SEG7_DEC_TIMEOUT_EN
            for (int i = 0; i < DIGITS; i++) begin
                if (expire[i]) begin
                    digit_valid[i] <= 1'b0;
                    digit_err[i]   <= 1'b0;
                end
            end
`endif

            for (int i = 0; i < DIGITS; i++) begin
                if (commit_vec[i]) begin
                    if (dec_hit) begin
                        value_out[i*4 +: 4] <= dec_nib;
                        digit_valid[i]      <= 1'b1;
                        digit_err[i]        <= 1'b0;
                    end else begin
                        digit_valid[i]      <= 1'b0;
                        digit_err[i]        <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int STABLE = 4;
    localparam int TO = 16;

    localparam logic [6:0] CODES [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk;
    logic rst;
    logic [4*ND-1:0] value_out;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   digit_err;
    logic            update;

    seg7_scan_decoder_if #(.DIGITS(ND)) bus ();

    seg7_scan_decoder #(
        .DIGITS         (ND),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .value_out   (value_out),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .update      (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    bit live     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a commit happens when the sample seen two edges late has been
    // identical and one-hot for exactly STABLE consecutive edges.
    logic [4*ND-1:0] m_value;
    logic [ND-1:0]   m_valid;
    logic [ND-1:0]   m_err;
    logic            m_update;
    logic [10:0]     hist [$];
    logic [10:0]     prev_s;
    int              run;
    int              age [ND];

    always @(posedge clk) begin
        logic [10:0] cur;
        logic [3:0]  cd;
        logic [3:0]  nib;
        bit          hit;
        bit          commit;
        if (rst) begin
            m_value  = '0;
            m_valid  = '0;
            m_err    = '0;
            m_update = 1'b0;
            hist     = '{11'h0, 11'h0};
            prev_s   = '0;
            run      = 0;
            for (int i = 0; i < ND; i++) age[i] = 0;
            live     = 1'b1;
        end else begin
            cur = hist[1];
            if (cur == prev_s) begin
                if (run < 1000) run++;
            end else begin
                run = 1;
            end
            prev_s = cur;
            cd = cur[10:7];
            commit = $onehot(cd) && (run == STABLE);
            m_update = commit;
            hit = 1'b0;
            nib = 4'h0;
            for (int k = 0; k < 16; k++) begin
                if (cur[6:0] == CODES[k[3:0]]) begin
                    hit = 1'b1;
                    nib = k[3:0];
                end
            end
            for (int i = 0; i < ND; i++) begin
                if (commit && cd[i]) begin
                    if (hit) begin
                        m_value[i*4 +: 4] = nib;
                        m_valid[i] = 1'b1;
                        m_err[i]   = 1'b0;
                    end else begin
                        m_valid[i] = 1'b0;
                        m_err[i]   = 1'b1;
                    end
                    age[i] = 0;
                end else if (age[i] < TO) begin
                    age[i]++;
`ifdef SEG7_DEC_TIMEOUT_EN
                    if (age[i] == TO) begin
                        m_valid[i] = 1'b0;
                        m_err[i]   = 1'b0;
                    end
`endif
                end
            end
            hist.push_front({bus.dig_sel, bus.seg_in});
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("value_out",   32'(value_out),   32'(m_value));
            chk("digit_valid", 32'(digit_valid), 32'(m_valid));
            chk("digit_err",   32'(digit_err),   32'(m_err));
            chk("update",      32'(update),      32'(m_update));
            if (update === 1'b1) upd_cnt++;
        end
    end

    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
        bus.dig_sel = d;
        bus.seg_in  = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int start;
        rst = 1'b1;
        bus.dig_sel = '0;
        bus.seg_in  = '0;
        repeat (3) @(negedge clk);
        chk("reset_value", 32'(value_out), 32'h0);
        chk("reset_flags", 32'({digit_valid, digit_err, update}), 32'h0);
        rst = 1'b0;
        drive(4'b0000, 7'h00, 4);

        // Digit 0 shows "3": commit appears after the 6th edge (edge 5).
        start = upd_cnt;
        bus.dig_sel = 4'b0001;
        bus.seg_in  = 7'b100_1111;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("latency_update", 32'(update), (k == 5) ? 32'h1 : 32'h0);
        end
        chk("t1_nibble0", 32'(value_out[3:0]), 32'h3);
        chk("t1_valid0",  32'(digit_valid[0]), 32'h1);
        drive(4'b0000, 7'h00, 4);
        chk("t1_pulses", 32'(upd_cnt - start), 32'h1);

        // Digit 2: legal 8, then illegal pattern keeps the 8.
        drive(4'b0100, 7'h7F, 8);
        drive(4'b0000, 7'h00, 2);
        drive(4'b0100, 7'b000_0001, 8);
        chk("t2_nibble2", 32'(value_out[11:8]), 32'h8);
        chk("t2_err2",    32'(digit_err[2]),    32'h1);
        chk("t2_valid2",  32'(digit_valid[2]),  32'h0);
        drive(4'b0000, 7'h00, 4);

        // Digit 1: A for only 3 cycles, then b: only b commits.
        start = upd_cnt;
        drive(4'b0010, 7'b111_0111, 3);
        drive(4'b0010, 7'b111_1100, 6);
        drive(4'b0000, 7'h00, 4);
        chk("t3_pulses",  32'(upd_cnt - start), 32'h1);
        chk("t3_nibble1", 32'(value_out[7:4]),  32'hB);

        // Overlapping strobes, then blanking: nothing commits.
        start = upd_cnt;
        drive(4'b0110, 7'h3F, 10);
        drive(4'b0000, 7'h3F, 10);
        chk("t4_pulses", 32'(upd_cnt - start), 32'h0);
        chk("t4_value",  32'(value_out),        32'h08B3);
`ifndef SEG7_DEC_TIMEOUT_EN
        chk("t4_valid", 32'(digit_valid), 32'h3);
        chk("t4_err",   32'(digit_err),   32'h4);
`endif
        drive(4'b0000, 7'h00, 3);

        // Two full scan passes of "1234".
        start = upd_cnt;
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < ND; d++) begin
                drive(4'(1 << d), CODES[4'(d + 1)], 8);
                drive(4'b0000, 7'h00, 2);
            end
        end
        chk("t5_pulses", 32'(upd_cnt - start), 32'h8);
        chk("t5_value",  32'(value_out),        32'h4321);
`ifndef SEG7_DEC_TIMEOUT_EN
        chk("t5_valid", 32'(digit_valid), 32'hF);
        chk("t5_err",   32'(digit_err),   32'h0);
`endif

        // Long idle: valid persists unless the refresh timeout is built in.
        drive(4'b0000, 7'h00, 20);
        chk("idle_value", 32'(value_out), 32'h4321);
`ifdef SEG7_DEC_TIMEOUT_EN
        chk("idle_valid0", 32'(digit_valid[0]), 32'h0);
`else
        chk("idle_valid0", 32'(digit_valid[0]), 32'h1);
`endif

        // Reset while the stability count sits at 3.
        bus.dig_sel = 4'b1000;
        bus.seg_in  = 7'h07;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_value",  32'(value_out),   32'h0);
        chk("rst_valid",  32'(digit_valid), 32'h0);
        chk("rst_err",    32'(digit_err),   32'h0);
        chk("rst_update", 32'(update),      32'h0);
        rst = 1'b0;
        drive(4'b0000, 7'h00, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart to the team's BCD-to-7-segment encoder. It watches a multiplexed 7-segment display bus: active-high segment lines plus one-hot digit strobes driven by an external or on-chip scanner. From that bus it recovers the 4-bit hex value shown on each digit. It sits on the display readback/self-test path and hands per-digit values, valid/error flags and an update strobe to the checker or CPU register file.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (1–8).
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a commit (≥2).
- `TIMEOUT_CYCLES`, default 65535: refresh timeout per digit. Used only when `SEG7_DEC_TIMEOUT_EN` is defined.
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `seg_in`  in  7: segment lines, bit6=g … bit0=a, active-high. Same encoding as the encoder.
- `dig_sel`  in  `DIGITS`: digit strobe; one-hot when a digit is lit.
- `value_out`  out  4*`DIGITS`: nibble i = last decoded value of digit i.
- `digit_valid`  out  `DIGITS`: digit i holds a legal decoded value.
- `digit_err`  out  `DIGITS`: last commit on digit i was an illegal pattern.
- `update`  out  1: one-cycle pulse on any commit.

## Operation
- Input stage: `{dig_sel, seg_in}` passes through a 2-flop synchronizer to give `s2`. `s3` is `s2` delayed by one cycle.
- Stability counter `cnt`, saturating at `STABLE_CYCLES`:
  - If `s2.dig_sel` is one-hot and `s2 == s3`: `cnt <= min(cnt+1, STABLE_CYCLES)`.
  - If `s2.dig_sel` is one-hot and `s2 != s3`: `cnt <= 1`.
  - If `s2.dig_sel` is zero or multi-hot (blanking/overlap): `cnt <= 0`, no commit.
- Commit fires on the edge where `cnt` goes from `STABLE_CYCLES-1` to `STABLE_CYCLES`. The target digit is i = index of `s2.dig_sel`.
  - Pattern matches one of the 16 encoder codes (0–F): nibble i <= code, `digit_valid[i] <= 1`, `digit_err[i] <= 0`.
  - No match (including all-off 7'b000_0000): `digit_err[i] <= 1`, `digit_valid[i] <= 0`, nibble i unchanged.
  - `update <= 1` for exactly that cycle.
- After saturation there is no further commit until the sample changes or blanks. Each fresh scan pass of a digit re-commits, so `update` pulses once per pass.
- Other digits' outputs are never touched by a commit to digit i.

## Timing
- Reset values: `value_out` = 0, `digit_valid` = 0, `digit_err` = 0, `update` = 0, `cnt` = 0. Synchronizer flops and timeout counters also clear to 0.
- Latency: input applied before edge 0 and held steady gives a commit visible after edge `STABLE_CYCLES`+1 (edge 5 at default).
- A pattern held only `STABLE_CYCLES`-1 synchronized cycles never commits.
- Reset asserted mid-count or on the commit edge wins: there is no commit, and all outputs read reset values on the next cycle.
- A change in `seg_in` alone (same digit) restarts counting at 1. No partial or glitch value is ever committed.

## Configuration
- `SEG7_DEC_TIMEOUT_EN` defined: each digit has a refresh counter.
  - The counter clears on every commit to that digit and otherwise increments, saturating.
  - On reaching `TIMEOUT_CYCLES`: `digit_valid[i] <= 0`, `digit_err[i] <= 0`, value retained. No `update` pulse.
  - A commit and a timeout on the same edge resolve as the commit.
- Not defined: valid persists until an error commit or reset, and no timeout logic is synthesized.

## Structure
- Shared package/header `seg7_pkg` holds the 16 segment code constants (0–F, as in the encoder) and the all-off blank code. Encoder and decoder must reference the same table.
- One sub-module, `seg7_pattern_decode`: combinational 7-bit pattern to `{hit, nibble[3:0]}`. It is instantiated once on `s2.seg_in`.

## Test plan
- `dig_sel`=4'b0001, `seg_in`=7'b100_1111 held 6 cycles → after edge 5: nibble0=3, `digit_valid`[0]=1, one `update` pulse.
- Digit 2, `seg_in`=7'b000_0001 held 6 cycles, with nibble2 previously 8 → `digit_err`[2]=1, `digit_valid`[2]=0, nibble2 still 8.
- Digit 1, pattern 7'b111_0111 held 3 cycles then switched to 7'b111_1100 for 6 cycles → no commit of A; nibble1=B only.
- `dig_sel`=4'b0110 with a valid pattern for 10 cycles → no `update`, outputs unchanged. Same test with 4'b0000 blanking.
- Full 4-digit scan "1234", 8 cycles per digit, 2 blank cycles between digits → `value_out`=16'h4321, 4 `update` pulses per pass.
- `rst` pulsed at `cnt`=3 → no commit; all outputs 0. With `SEG7_DEC_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: digit 0 not refreshed for 16 cycles → `digit_valid`[0] drops, nibble retained.
